clock_sub: RTL and testbench
============================

Name: clock_sub

Overview:
- Countdown core of the kitchen timer, holding an MM:SS value as four BCD digits.
- A new preset on the four digit inputs is loaded automatically; after that the value counts down one second per tick until it reaches 00:00, then holds.
- Sits between the preset-entry logic (buttons/switches) and the 7-segment display driver.

Parameters:
- CLK_DIV, default 1: number of CLK rising edges per one-second tick. 1 means every edge is a second; the timer's CLK is the 1 Hz domain.
- DIGIT_W, default 8: width of each digit port. The value sits in bits [3:0]; the upper bits are always 0 on outputs and ignored on inputs.

Ports:
- CLK  in  1  single system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- seconds_upper_in  in  DIGIT_W  preset tens-of-seconds digit, 0..5.
- seconds_lower_in  in  DIGIT_W  preset units-of-seconds digit, 0..9.
- minutes_upper_in  in  DIGIT_W  preset tens-of-minutes digit, 0..9.
- minutes_lower_in  in  DIGIT_W  preset units-of-minutes digit, 0..9.
- seconds_upper  out  DIGIT_W  current tens-of-seconds.
- seconds_lower  out  DIGIT_W  current units-of-seconds.
- minutes_upper  out  DIGIT_W  current tens-of-minutes.
- minutes_lower  out  DIGIT_W  current units-of-minutes.

Behaviour:
- Reset (reset=0, async): all four outputs = 0, shadow preset register = 0, prescaler = 0. Outputs are registered, with no combinational path from inputs.
- Input sanitising: only bits [3:0] of each input are used. seconds_upper_in >5 saturates to 5; any other digit >9 saturates to 9.
- Preset-change detection: a shadow register holds the last loaded raw preset (bits [3:0] of all four inputs). This takes priority over counting.
- On a rising edge where any input nibble differs from the shadow:
  - shadow <= inputs
  - count <= sanitised inputs
  - prescaler <= 0
  - New value appears on outputs 1 cycle after the change is present at an edge.
- Otherwise, if count != 00:00:
  - If prescaler == CLK_DIV-1, decrement count by one second and set prescaler <= 0.
  - Else prescaler <= prescaler+1.
- Decrement with BCD borrow chain:
  - seconds_lower 0 -> 9, borrow into seconds_upper.
  - seconds_upper 0 -> 5, borrow into minutes_lower.
  - minutes_lower 0 -> 9, borrow into minutes_upper.
  - 00:01 -> 00:00.
- At 00:00: count holds and prescaler holds at 0. It stays there until a new preset differs from the shadow.
- Preset equal to the shadow (e.g. re-applying the same value) does not reload.
- Coming out of reset with inputs all zero: no load, and the timer idles at 00:00.
- Reset mid-count: immediate clear to 00:00 and shadow = 0. A nonzero preset still on the inputs then reloads on the first edge after reset deasserts.
- Range: 00:00 to 99:59.

Optional Feature:
- Macro CLOCK_SUB_DONE_EN.
- When defined, adds output port done (1 bit, registered):
  - done = 1 on the cycle the count transitions 00:01 -> 00:00, and stays 1 while the count is 00:00 following a countdown.
  - Cleared by reset or by a new preset load.
  - A load of 00:00 leaves done = 0.
- When undefined, the done port and its logic are absent, and the port list is exactly as above.

Test Plan:
- Reset with all inputs 0, release reset -> outputs 0,0,0,0 and stay there for 20 edges.
- Inputs change from 0 to seconds_upper=4, seconds_lower=4, minutes_upper=4, minutes_lower=5 -> next edge outputs show 45:44; following edges show 45:43, 45:42, ... (CLK_DIV=1).
- Borrow chain: preset 10:00 -> next ticks 09:59, then 09:58. Preset 00:10 -> 00:09.
- Terminal: preset 00:02 -> 00:01 -> 00:00, then holds 00:00 for 10 edges. With CLOCK_SUB_DONE_EN, done goes 1 at 00:00.
- Saturation/reload: inputs seconds_upper=7, seconds_lower=12, minutes 0x0F,0x1A -> loads 99:59 (upper nibbles ignored). Re-applying the same inputs mid-count does not reload; changing one digit reloads.
- Async reset mid-count at 30:15 (reset pulsed low between edges) -> outputs 0 immediately. After release, a 30:15 preset still on the inputs reloads next edge. With CLK_DIV=4, each decrement takes exactly 4 edges.

Source files
------------

// File: rtl/clock_sub.sv
// Kitchen-timer countdown core: MM:SS held as four BCD digits, auto-loads a changed preset.
// Optional `CLOCK_SUB_DONE_EN adds a registered done flag raised when a countdown reaches 00:00.
module clock_sub #(
    parameter int CLK_DIV = 1,
    parameter int DIGIT_W = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] seconds_upper_in,
    input  logic [DIGIT_W-1:0] seconds_lower_in,
    input  logic [DIGIT_W-1:0] minutes_upper_in,
    input  logic [DIGIT_W-1:0] minutes_lower_in,
    output logic [DIGIT_W-1:0] seconds_upper,
    output logic [DIGIT_W-1:0] seconds_lower,
    output logic [DIGIT_W-1:0] minutes_upper,
    output logic [DIGIT_W-1:0] minutes_lower
`ifdef CLOCK_SUB_DONE_EN
    ,
    output logic               done
`endif
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [3:0]    su_q, sl_q, mu_q, ml_q;
    logic [3:0]    su_d, sl_d, mu_d, ml_d;
    logic [15:0]   shadow_q;
    logic [15:0]   raw;
    logic [PW-1:0] pre_q;
    logic          load, is_zero, tick, dec_to_zero;
    logic          unused_hi;

    function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    // Only the low nibble of each digit port carries the value.
    assign raw       = {minutes_upper_in[3:0], minutes_lower_in[3:0],
                        seconds_upper_in[3:0], seconds_lower_in[3:0]};
    assign unused_hi = ^{seconds_upper_in, seconds_lower_in, minutes_upper_in, minutes_lower_in};

    assign load    = (raw != shadow_q);
    assign is_zero = ({mu_q, ml_q, su_q, sl_q} == 16'h0000);
    assign tick    = (pre_q == PW'(CLK_DIV - 1));

    // One-second BCD decrement; only applied while the count is non-zero.
    always_comb begin
        su_d = su_q;
        sl_d = sl_q;
        mu_d = mu_q;
        ml_d = ml_q;
        if (sl_q != 4'd0) begin
            sl_d = sl_q - 4'd1;
        end else begin
            sl_d = 4'd9;
            if (su_q != 4'd0) begin
                su_d = su_q - 4'd1;
            end else begin
                su_d = 4'd5;
                if (ml_q != 4'd0) begin
                    ml_d = ml_q - 4'd1;
                end else begin
                    ml_d = 4'd9;
                    mu_d = mu_q - 4'd1;
                end
            end
        end
    end

    assign dec_to_zero = ({mu_d, ml_d, su_d, sl_d} == 16'h0000);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            su_q     <= '0;
            sl_q     <= '0;
            mu_q     <= '0;
            ml_q     <= '0;
            shadow_q <= '0;
            pre_q    <= '0;
        end else if (load) begin
            shadow_q <= raw;
            su_q     <= sat(seconds_upper_in[3:0], 4'd5);
            sl_q     <= sat(seconds_lower_in[3:0], 4'd9);
            mu_q     <= sat(minutes_upper_in[3:0], 4'd9);
            ml_q     <= sat(minutes_lower_in[3:0], 4'd9);
            pre_q    <= '0;
        end else if (!is_zero) begin
            if (tick) begin
                su_q  <= su_d;
                sl_q  <= sl_d;
                mu_q  <= mu_d;
                ml_q  <= ml_d;
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

`ifdef CLOCK_SUB_DONE_EN
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else if (load) begin
            done <= 1'b0;
        end else if (!is_zero && tick && dec_to_zero) begin
            done <= 1'b1;
        end
    end
`else
    logic unused_dec;
    assign unused_dec = dec_to_zero;
`endif

    assign seconds_upper = DIGIT_W'(su_q);
    assign seconds_lower = DIGIT_W'(sl_q);
    assign minutes_upper = DIGIT_W'(mu_q);
    assign minutes_lower = DIGIT_W'(ml_q);

endmodule

// File: tb/tb_clock_sub.sv
// Scoreboard bench for clock_sub: a seconds-count reference model pushes per-edge
// expectations for a CLK_DIV=1 and a CLK_DIV=4 instance; they are popped after each edge.
module tb_clock_sub;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] su_in = '0, sl_in = '0, mu_in = '0, ml_in = '0;
    logic [DW-1:0] su1, sl1, mu1, ml1, su4, sl4, mu4, ml4;
    logic          done1, done4;

    int errors = 0;
    int checks = 0;

    clock_sub #(.CLK_DIV(1), .DIGIT_W(DW)) dut1 (
        .CLK(CLK), .reset(reset),
        .seconds_upper_in(su_in), .seconds_lower_in(sl_in),
        .minutes_upper_in(mu_in), .minutes_lower_in(ml_in),
        .seconds_upper(su1), .seconds_lower(sl1),
        .minutes_upper(mu1), .minutes_lower(ml1)
`ifdef CLOCK_SUB_DONE_EN
        , .done(done1)
`endif
    );

    clock_sub #(.CLK_DIV(4), .DIGIT_W(DW)) dut4 (
        .CLK(CLK), .reset(reset),
        .seconds_upper_in(su_in), .seconds_lower_in(sl_in),
        .minutes_upper_in(mu_in), .minutes_lower_in(ml_in),
        .seconds_upper(su4), .seconds_lower(sl4),
        .minutes_upper(mu4), .minutes_lower(ml4)
`ifdef CLOCK_SUB_DONE_EN
        , .done(done4)
`endif
    );

`ifndef CLOCK_SUB_DONE_EN
    assign done1 = 1'b0;
    assign done4 = 1'b0;
`endif

    always #5 CLK = ~CLK;

    // Reference model state: total seconds remaining, per instance.
    int m_t[2], m_pre[2], m_done[2], m_div[2];
    logic [15:0] m_shadow[2];
    logic [32:0] q0[$], q1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int sat(input logic [DW-1:0] d, input int max);
        return (int'(d[3:0]) > max) ? max : int'(d[3:0]);
    endfunction

    task automatic model_step(input int k);
        logic [15:0] raw;
        raw = {mu_in[3:0], ml_in[3:0], su_in[3:0], sl_in[3:0]};
        if (!reset) begin
            m_t[k] = 0; m_pre[k] = 0; m_done[k] = 0; m_shadow[k] = '0;
        end else if (raw != m_shadow[k]) begin
            m_shadow[k] = raw;
            m_t[k] = sat(mu_in, 9) * 600 + sat(ml_in, 9) * 60 + sat(su_in, 5) * 10 + sat(sl_in, 9);
            m_pre[k] = 0;
            m_done[k] = 0;
        end else if (m_t[k] != 0) begin
            if (m_pre[k] == m_div[k] - 1) begin
                m_t[k]--;
                m_pre[k] = 0;
                if (m_t[k] == 0) m_done[k] = 1;
            end else begin
                m_pre[k]++;
            end
        end
    endtask

    function automatic logic [32:0] expect_of(input int k);
        int mm, ss;
        logic [31:0] d;
        mm = m_t[k] / 60;
        ss = m_t[k] % 60;
        d = {8'(mm / 10), 8'(mm % 10), 8'(ss / 10), 8'(ss % 10)};
        return {m_done[k] != 0, d};
    endfunction

    task automatic compare(input string tag, input int k, input logic [31:0] got, input logic gdone);
        logic [32:0] e;
        if (k == 0 ? q0.size() == 0 : q1.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check(tag, got, e[31:0]);
`ifdef CLOCK_SUB_DONE_EN
            check({tag, "_done"}, {31'd0, gdone}, {31'd0, e[32]});
`else
            if (gdone) check({tag, "_done"}, 32'd1, 32'd0);
`endif
        end
    endtask

    task automatic tick(input string tag);
        for (int k = 0; k < 2; k++) model_step(k);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        @(posedge CLK);
        #1;
        compare({tag, "_d1"}, 0, {mu1, ml1, su1, sl1}, done1);
        compare({tag, "_d4"}, 1, {mu4, ml4, su4, sl4}, done4);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic preset(input logic [DW-1:0] mu, ml, su, sl);
        mu_in = mu; ml_in = ml; su_in = su; sl_in = sl;
    endtask

    initial begin
        m_div[0] = 1;
        m_div[1] = 4;
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 0; m_pre[k] = 0; m_done[k] = 0; m_shadow[k] = '0;
        end

        #2;
        check("reset_d1", {mu1, ml1, su1, sl1}, 32'h0);
        check("reset_d4", {mu4, ml4, su4, sl4}, 32'h0);
        run("in_reset", 2);
        reset = 1'b1;
        run("idle", 20);

        preset(8'd4, 8'd5, 8'd4, 8'd4);
        tick("load4544");
        check("direct_4544", {mu1, ml1, su1, sl1}, 32'h04050404);
        run("count4544", 5);
        check("direct_4539", {mu1, ml1, su1, sl1}, 32'h04050309);

        preset(8'd1, 8'd0, 8'd0, 8'd0);
        run("borrow1000", 3);
        check("direct_0958", {mu1, ml1, su1, sl1}, 32'h00090508);
        preset(8'd0, 8'd0, 8'd1, 8'd0);
        run("borrow0010", 2);

        preset(8'd0, 8'd0, 8'd0, 8'd2);
        run("terminal", 13);
        check("direct_0000", {mu1, ml1, su1, sl1}, 32'h0);
        preset(8'd0, 8'd0, 8'd0, 8'd0);
        run("load0000", 3);

        preset(8'h0F, 8'h1A, 8'd7, 8'd12);
        tick("saturate");
        check("direct_9959", {mu1, ml1, su1, sl1}, 32'h09090509);
        run("sat_count", 3);
        preset(8'h0F, 8'h1A, 8'd7, 8'd12);
        run("reapply", 3);
        preset(8'h0F, 8'h1A, 8'd7, 8'd3);
        run("one_digit", 3);
        preset(8'h3F, 8'hFA, 8'h17, 8'h23);
        run("upper_bits", 2);

        preset(8'd3, 8'd0, 8'd1, 8'd5);
        run("load3015", 3);
        #3;
        reset = 1'b0;
        #1;
        check("async_clr_d1", {mu1, ml1, su1, sl1}, 32'h0);
        check("async_clr_d4", {mu4, ml4, su4, sl4}, 32'h0);
        tick("held_reset");
        reset = 1'b1;
        run("reload3015", 14);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
